// File: rtl/task_enqueue_if.sv
// Request and TaskFIFO write bundle between the scheduler, task_enqueue and the per-level FIFOs.
// slave is the enqueue block; master drives requests and FIFO full flags.
interface task_enqueue_if #(
    parameter int PTW      = 16,
    parameter int MTW      = 16,
    parameter int LEVEL    = 4,
    parameter int TREE_NUM = 4
);
    localparam int TNB = $clog2(TREE_NUM);
    localparam int DW  = (PTW + MTW) + 2 * TNB + 2;

    logic                 push;
    logic [TNB-1:0]       push_tree_id;
    logic [PTW+MTW-1:0]   push_data;
    logic                 pop;
    logic [TNB-1:0]       pop_tree_id;
    logic                 ready;
    logic [LEVEL-1:0]     fifo_push;
    logic [DW-1:0]        fifo_data;
    logic [LEVEL-1:0]     fifo_full;

    modport slave (
        input  push, push_tree_id, push_data, pop, pop_tree_id, fifo_full,
        output ready, fifo_push, fifo_data
    );

    modport master (
        output push, push_tree_id, push_data, pop, pop_tree_id, fifo_full,
        input  ready, fifo_push, fifo_data
    );
endinterface

// File: rtl/task_enqueue.sv
// Encodes scheduler push/pop requests into TaskFIFO entries and writes them to a non-full level FIFO.
// Latency: request accepted at edge N is written during cycle N+1; one entry per cycle sustained.
// Backpressure: ready drops while the staged entry has no writable FIFO; TASKENQ_AFFINITY_EN pins target to treeId % LEVEL.
module task_enqueue #(
    parameter int PTW      = 16,
    parameter int MTW      = 16,
    parameter int LEVEL    = 4,
    parameter int TREE_NUM = 4
) (
    input  logic                i_clk,
    input  logic                i_arst_n,
    task_enqueue_if.slave       bus,
    output logic [15:0]         o_stall_cnt
);
    localparam int TNB = $clog2(TREE_NUM);
    localparam int LB  = (LEVEL > 1) ? $clog2(LEVEL) : 1;
    localparam int DW  = (PTW + MTW) + 2 * TNB + 2;

    logic              st_valid;
    logic [DW-1:0]     st_entry;
    logic [DW-1:0]     enc;
    logic [LB-1:0]     tgt;
    logic              found;
    logic              drain;
    logic              accept;

    // Merged push+pop keeps both bits set; the consumer runs the push half first.
    assign enc = {bus.push,
                  bus.pop,
                  bus.push ? bus.push_tree_id : {TNB{1'b0}},
                  bus.pop  ? bus.pop_tree_id  : {TNB{1'b0}},
                  bus.push ? bus.push_data    : {(PTW + MTW){1'b0}}};

    assign drain     = st_valid && found;
    assign bus.ready = !st_valid || drain;
    assign accept    = (bus.push || bus.pop) && bus.ready;

    assign bus.fifo_push = drain ? (LEVEL'(1) << tgt) : '0;
    assign bus.fifo_data = st_valid ? st_entry : '0;

`ifdef TASKENQ_AFFINITY_EN
    logic [LB-1:0]  st_tgt;
    logic [TNB-1:0] acc_tree_id;

    assign acc_tree_id = bus.push ? bus.push_tree_id : bus.pop_tree_id;
    assign tgt         = st_tgt;
    assign found       = !bus.fifo_full[st_tgt];

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            st_tgt <= '0;
        end else if (accept) begin
            st_tgt <= LB'(int'(acc_tree_id) % LEVEL);
        end
    end
`else
    logic [LB-1:0] rr_ptr;
    int            scan_idx;

    // Walk downward so the closest non-full level to rr_ptr is the one left in tgt.
    always_comb begin
        tgt      = '0;
        found    = 1'b0;
        scan_idx = 0;
        for (int k = LEVEL - 1; k >= 0; k--) begin
            scan_idx = (int'(rr_ptr) + k) % LEVEL;
            if (!bus.fifo_full[LB'(scan_idx)]) begin
                tgt   = LB'(scan_idx);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            rr_ptr <= '0;
        end else if (drain) begin
            rr_ptr <= LB'((int'(tgt) + 1) % LEVEL);
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            st_valid <= 1'b0;
            st_entry <= '0;
        end else if (accept) begin
            st_valid <= 1'b1;
            st_entry <= enc;
        end else if (drain) begin
            st_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_stall_cnt <= '0;
        end else if (st_valid && !found && (o_stall_cnt != 16'hFFFF)) begin
            o_stall_cnt <= o_stall_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_task_enqueue.sv
// Directed bench for task_enqueue: requests push expected FIFO writes into a scoreboard, a negedge monitor checks them.
module tb_task_enqueue;
    localparam int DW = 38;

`ifdef TASKENQ_AFFINITY_EN
    localparam logic [3:0] S2  = 4'b0100;
    localparam logic [3:0] S4  = 4'b0001;
    localparam logic [3:0] S5A = 4'b0001;
    localparam logic [3:0] S5B = 4'b0010;
    localparam logic [3:0] F5  = 4'b1110;
`else
    localparam logic [3:0] S2  = 4'b0001;
    localparam logic [3:0] S4  = 4'b1000;
    localparam logic [3:0] S5A = 4'b1000;
    localparam logic [3:0] S5B = 4'b1000;
    localparam logic [3:0] F5  = 4'b0111;
`endif

    logic        clk = 1'b0;
    logic        arst_n;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    task_enqueue_if #(.PTW(16), .MTW(16), .LEVEL(4), .TREE_NUM(4)) bus ();

    task_enqueue #(.PTW(16), .MTW(16), .LEVEL(4), .TREE_NUM(4)) dut (
        .i_clk       (clk),
        .i_arst_n    (arst_n),
        .bus         (bus.slave),
        .o_stall_cnt (stall_cnt)
    );

    typedef struct {
        logic [3:0]    strobe;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    function automatic logic [DW-1:0] entry(input logic p, input logic q, input logic [1:0] pt,
                                            input logic [1:0] qt, input logic [31:0] d);
        return {p, q, pt, qt, d};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_write(input logic [3:0] s, input logic [DW-1:0] d);
        exp_t e;
        e.strobe = s;
        e.data   = d;
        sb.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_req();
        bus.push         = 1'b0;
        bus.pop          = 1'b0;
        bus.push_tree_id = 2'd0;
        bus.pop_tree_id  = 2'd0;
        bus.push_data    = 32'h0;
    endtask

    // Drive a request, hold it until accepted (bounded), then release it.
    task automatic send(input logic p, input logic q, input logic [1:0] pt, input logic [1:0] qt,
                        input logic [31:0] d, input logic [3:0] s, input logic [DW-1:0] exp_d);
        int n;
        bus.push         = p;
        bus.pop          = q;
        bus.push_tree_id = pt;
        bus.pop_tree_id  = qt;
        bus.push_data    = d;
        expect_write(s, exp_d);
        n = 0;
        while (!bus.ready && n < 50) begin
            cyc(1);
            n++;
        end
        if (n == 50) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: ready stayed %0b, required 1", bus.ready);
        end
        cyc(1);
        clear_req();
    endtask

    always @(negedge clk) begin
        if (arst_n && bus.fifo_push != 4'b0000) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: strobe %b data %h, required no write",
                         bus.fifo_push, bus.fifo_data);
            end else begin
                mon_e = sb.pop_front();
                check("write_strobe", 64'(bus.fifo_push), 64'(mon_e.strobe));
                check("write_data", 64'(bus.fifo_data), 64'(mon_e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [1:0] tp_tid [5];
    logic [3:0] tp_str [5];

    initial begin
        int n;
        tp_tid = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
        tp_str = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};

        arst_n        = 1'b0;
        bus.fifo_full = 4'b0000;
        clear_req();
        cyc(2);
        check("reset_ready", 64'(bus.ready), 64'd1);
        check("reset_push", 64'(bus.fifo_push), 64'd0);
        check("reset_data", 64'(bus.fifo_data), 64'd0);
        check("reset_stall", 64'(stall_cnt), 64'd0);
        arst_n = 1'b1;
        cyc(1);

        // Push only into empty FIFOs.
        send(1, 0, 2'd2, 2'd3, 32'h0001_0005, S2, entry(1, 0, 2'd2, 2'd0, 32'h0001_0005));
        // Merged push+pop.
        send(1, 1, 2'd1, 2'd3, 32'h0000_000A, 4'b0010, entry(1, 1, 2'd1, 2'd3, 32'h0000_000A));
        // Pop only with junk on the push fields, FIFO 2 full.
        bus.fifo_full = 4'b0100;
        send(0, 1, 2'd3, 2'd0, 32'hDEAD_BEEF, S4, entry(0, 1, 2'd0, 2'd0, 32'h0));
        cyc(1);
        bus.fifo_full = 4'b0000;

        // All FIFOs full: first push stages and blocks, second is held by the requester.
        bus.fifo_full    = 4'b1111;
        bus.push         = 1'b1;
        bus.push_tree_id = 2'd0;
        bus.push_data    = 32'h11;
        expect_write(S5A, entry(1, 0, 2'd0, 2'd0, 32'h11));
        check("t5_ready_before", 64'(bus.ready), 64'd1);
        cyc(1);
        bus.push_tree_id = 2'd1;
        bus.push_data    = 32'h22;
        check("t5_ready_blocked", 64'(bus.ready), 64'd0);
        check("t5_stall_start", 64'(stall_cnt), 64'd0);
        cyc(5);
        check("t5_stall_5", 64'(stall_cnt), 64'd5);
        check("t5_ready_still_blocked", 64'(bus.ready), 64'd0);
        check("t5_no_strobe", 64'(bus.fifo_push), 64'd0);
        bus.fifo_full = F5;
        expect_write(S5B, entry(1, 0, 2'd1, 2'd0, 32'h22));
        #1;
        check("t5_ready_on_drain", 64'(bus.ready), 64'd1);
        cyc(1);
        clear_req();
        cyc(1);
        bus.fifo_full = 4'b0000;
        cyc(1);

`ifdef TASKENQ_AFFINITY_EN
        // Pop tree 3 pinned to FIFO 3 while it is full.
        bus.fifo_full = 4'b1000;
        bus.pop         = 1'b1;
        bus.pop_tree_id = 2'd3;
        expect_write(4'b1000, entry(0, 1, 2'd0, 2'd3, 32'h0));
        cyc(1);
        clear_req();
        for (int i = 0; i < 3; i++) begin
            check("aff_no_strobe", 64'(bus.fifo_push), 64'd0);
            check("aff_ready_low", 64'(bus.ready), 64'd0);
            cyc(1);
        end
        bus.fifo_full = 4'b0000;
        cyc(1);
`else
        // Round-robin skips full FIFO 0 from rr_ptr 0.
        bus.fifo_full = 4'b1001;
        send(0, 1, 2'd0, 2'd2, 32'h0, 4'b0010, entry(0, 1, 2'd0, 2'd2, 32'h0));
        cyc(1);
        bus.fifo_full = 4'b0000;
`endif

        // Back-to-back pushes, wrapping past FIFO 3.
        for (int i = 0; i < 5; i++) begin
            check("tput_ready", 64'(bus.ready), 64'd1);
            send(1, 0, tp_tid[i], 2'd0, 32'h100 + i, tp_str[i],
                 entry(1, 0, tp_tid[i], 2'd0, 32'h100 + i));
        end
        cyc(1);
        check("idle_push", 64'(bus.fifo_push), 64'd0);
        check("idle_data", 64'(bus.fifo_data), 64'd0);

        // Reset while an entry is stalled: it must never be written.
        bus.fifo_full    = 4'b1111;
        bus.push         = 1'b1;
        bus.push_tree_id = 2'd3;
        bus.push_data    = 32'h33;
        cyc(1);
        clear_req();
        cyc(2);
        check("t1_ready_stalled", 64'(bus.ready), 64'd0);
        arst_n = 1'b0;
        #1;
        check("t1_push", 64'(bus.fifo_push), 64'd0);
        check("t1_ready", 64'(bus.ready), 64'd1);
        check("t1_stall", 64'(stall_cnt), 64'd0);
        check("t1_data", 64'(bus.fifo_data), 64'd0);
        cyc(1);
        arst_n        = 1'b1;
        bus.fifo_full = 4'b0000;
        cyc(4);
        check("t1_no_write", 64'(bus.fifo_push), 64'd0);

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            cyc(1);
            n++;
        end
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
